// File: rtl/branch_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl_pkg
//   Shared defines for the integer pipeline control logic: the branch funct3
//   codes used by the branch unit, and the state encodings of the
//   branch/load-use hazard controller.
// -----------------------------------------------------------------------------
package branch_hazard_ctrl_pkg;

    // Branch funct3 codes (RV32I B-type)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Hazard controller FSM states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_t;

    // Width of the stall/flush down-counter
    localparam int HZ_CNT_W = 3;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    // x0 is never a real dependency.
    function automatic logic load_use_hazard(
        input logic       memread_ex,
        input logic [4:0] rd_ex,
        input logic [4:0] rs1_id,
        input logic [4:0] rs2_id,
        input logic       use_rs1_id,
        input logic       use_rs2_id
    );
        return memread_ex && (rd_ex != 5'd0) &&
               ((use_rs1_id && (rs1_id == rd_ex)) ||
                (use_rs2_id && (rs2_id == rd_ex)));
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter for pipeline statistics. Counts one per cycle with
//   inc high, sticks at all-ones and never wraps.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the count
//   inc    in   increment request
//   count  out  current count [width-1:0]
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [width-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//   Control-hazard and load-use hazard unit for a 5-stage pipeline.
//   - A taken branch or jump resolved in EX redirects fetch to target_ex and
//     squashes the wrong-path instructions in IF/ID and ID/EX, then keeps
//     flushing for FLUSH_CYCLES further cycles.
//   - A load in EX feeding the instruction in ID freezes PC and IF/ID for
//     LOAD_STALL cycles while bubbles go into ID/EX.
//   Outputs are decoded combinationally from state and the current EX/ID
//   inputs, so the redirect takes effect in the same cycle it is resolved.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   branch_taken_ex, jump_ex      redirect sources from EX
//   target_ex[31:0]               redirect address
//   memread_ex, rd_ex[4:0]        load in EX and its destination
//   rs1_id, rs2_id[4:0]           ID source registers
//   use_rs1_id, use_rs2_id        ID actually reads that source
//   pc_write, ifid_write          PC / IF-ID enables
//   ifid_flush, idex_flush        bubble insertion
//   pc_sel, pc_target[31:0]       next-PC select and redirect address
//   redirect_cnt, stall_cnt       saturating statistics [CNT_W-1:0]
// -----------------------------------------------------------------------------
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,   // 0..7
    parameter int LOAD_STALL   = 1,   // 1..7
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken_ex,
    input  logic             jump_ex,
    input  logic [31:0]      target_ex,
    input  logic             memread_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [HZ_CNT_W-1:0] FLUSH_INIT = HZ_CNT_W'(FLUSH_CYCLES);
    localparam logic [HZ_CNT_W-1:0] STALL_INIT = HZ_CNT_W'(LOAD_STALL - 1);

    hz_state_t           state_q, state_d;
    logic [HZ_CNT_W-1:0] cnt_q,   cnt_d;
    logic                redirect;
    logic                hazard;
    logic                redirect_inc;
    logic                stall_inc;

    assign redirect  = branch_taken_ex | jump_ex;
    assign hazard    = load_use_hazard(memread_ex, rd_ex, rs1_id, rs2_id,
                                       use_rs1_id, use_rs2_id);
    assign pc_target = target_ex;

    // ------------------------------------------------------------------
    // Next state and Mealy outputs
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pc_sel       = 1'b0;
        redirect_inc = 1'b0;
        stall_inc    = 1'b0;

        if (state_q == ST_FLUSH) begin
            // Instructions arriving now are wrong-path: squash them and
            // ignore whatever redirect or hazard they appear to carry.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q <= 1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else if (redirect) begin
            // From RUN or STALL: a redirect wins over any load-use stall,
            // since the stalled instruction is itself on the wrong path.
            pc_sel       = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redirect_inc = 1'b1;
            if (FLUSH_CYCLES == 0) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_INIT;
            end
        end else if ((state_q == ST_STALL) || hazard) begin
            // Freeze fetch/decode, bubble into EX.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            if (state_q == ST_RUN) begin
                // The current cycle is the first stall cycle.
                if (LOAD_STALL <= 1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_STALL;
                    cnt_d   = STALL_INIT;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
        end

        // Hold the pipeline quiet and flushed while in reset.
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            pc_sel       = 1'b0;
            redirect_inc = 1'b0;
            stall_inc    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State register; reset aborts any stall or flush in progress
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.width(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_inc),
        .count (redirect_cnt)
    );

    sat_counter #(.width(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1: extra cycles fetch/decode stay flushed after a redirect (range 0..7).
REQ-002 SHALL have parameter LOAD_STALL, default 1: cycles fetch is frozen on a load-use hazard (range 1..7).
REQ-003 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-004 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port branch_taken_ex, input, 1: branch unit result for the instruction in EX.
REQ-007 SHALL have port jump_ex, input, 1: JAL/JALR in EX.
REQ-008 SHALL have port target_ex, input, 32: resolved redirect address.
REQ-009 SHALL have port memread_ex, input, 1: the instruction in EX is a load.
REQ-010 SHALL have port rd_ex, input, 5: destination register of the instruction in EX.
REQ-011 SHALL have ports rs1_id and rs2_id, input, 5 each: source registers of the instruction in ID.
REQ-012 SHALL have ports use_rs1_id and use_rs2_id, input, 1 each: the instruction in ID reads that source.
REQ-013 SHALL have ports pc_write and ifid_write, output, 1 each: PC and IF/ID register enables.
REQ-014 SHALL have ports ifid_flush and idex_flush, output, 1 each: insert a bubble into that register.
REQ-015 SHALL have port pc_sel, output, 1: 1 selects pc_target as the next PC.
REQ-016 SHALL have port pc_target, output, 32: equals target_ex.
REQ-017 SHALL have ports redirect_cnt and stall_cnt, output, CNT_W each: statistics counters.

Function
REQ-018 SHALL define redirect as branch_taken_ex | jump_ex, and hazard as memread_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
REQ-019 SHALL implement a three-state FSM (RUN, STALL, FLUSH) with a 3-bit down-counter; outputs are Mealy, decoded from state and current inputs.
REQ-020 SHALL, in RUN with redirect: pc_sel=1, pc_write=1, ifid_flush=1, idex_flush=1; next state FLUSH with counter=FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
REQ-021 SHALL, in RUN with hazard and no redirect: pc_write=0, ifid_write=0, idex_flush=1; next state RUN if LOAD_STALL=1, else STALL with counter=LOAD_STALL-1.
REQ-022 SHALL, in RUN with neither condition: pc_write=1, ifid_write=1, no flush, pc_sel=0.
REQ-023 SHALL, in STALL: drive the same outputs as REQ-021 regardless of hazard; decrement counter; return to RUN when counter reaches 0.
REQ-024 SHALL, in STALL with redirect: abandon the stall and act exactly as REQ-020 (redirect has priority).
REQ-025 SHALL, in FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, pc_sel=0; ignore redirect and hazard (wrong-path bubbles); decrement counter; go to RUN at 0.
REQ-026 SHALL, when redirect and hazard are both true in RUN, apply the redirect only; no stall is counted.
REQ-027 SHALL increment redirect_cnt on each accepted redirect (REQ-020, REQ-024) and stall_cnt on each stalled cycle (REQ-021, REQ-023); both saturate at all-ones and never wrap.

Reset
REQ-028 SHALL, while rst_n=0: state RUN, counter 0, redirect_cnt=0, stall_cnt=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pc_sel=0.
REQ-029 SHALL, on reset assertion during STALL or FLUSH, abort immediately with no pending redirect or stall retained after release.

Structure
REQ-030 SHALL place the FSM state encodings in the shared defines file, alongside the existing branch funct3 codes.
REQ-031 SHALL use one sub-module, sat_counter (parameter width, ports clk, rst_n, inc, count), instantiated twice.

Verification
REQ-032 SHALL cover BEQ taken: branch_taken_ex=1, target_ex=0x0000_0040 -> same cycle pc_sel=1, pc_target=0x40, both flushes asserted; next cycle FLUSH flushes; redirect_cnt=1.
REQ-033 SHALL cover load-use: memread_ex=1, rd_ex=5, rs2_id=5, use_rs2_id=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
REQ-034 SHALL cover the x0 case: memread_ex=1, rd_ex=0, rs1_id=0 -> no stall.
REQ-035 SHALL cover priority: redirect and hazard in the same cycle -> redirect only; stall_cnt unchanged. With LOAD_STALL=3, a redirect in the 2nd stall cycle ends the stall.
REQ-036 SHALL cover saturation and reset: CNT_W=4 with 17 redirects -> redirect_cnt=15; rst_n low mid-FLUSH -> REQ-028 values; first cycle after release is RUN.
